// File: rtl/fast_command_scheduler.sv
// Fast-command serializer: arbitrates a per-orbit BCR slot and NREQ requesters into framed 8-bit words.
// Latency: ack/word_strobe/first bit one cycle after the load edge; no backpressure, one word every 8 clocks.
// Optional collision counter built when FC_SCHED_COLLISION_CNT_EN is defined.
module fast_command_scheduler #(
    parameter int NREQ      = 4,
    parameter int ORBIT_LEN = 3564,
    parameter int BC_W      = 12
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 enable,
    input  logic [NREQ-1:0]      req,
    input  logic [4*NREQ-1:0]    req_code,
    output logic [NREQ-1:0]      ack,
    input  logic                 orbit_en,
    input  logic [3:0]           bcr_code,
    input  logic [BC_W-1:0]      bcr_offset,
    output logic                 fc_out,
    output logic                 word_strobe,
    output logic [BC_W-1:0]      bc_count,
    output logic [15:0]          collision_count
);

    localparam logic [7:0]      IDLE_WORD = 8'b1100_0001;
    localparam logic [BC_W-1:0] BC_LAST   = BC_W'(ORBIT_LEN - 1);

    logic [2:0]      bit_ctr_q;
    logic [7:0]      sr_q, sr_d;
    logic [BC_W-1:0] bc_q, bc_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            strobe_q;
    logic            load;
    logic            bcr_fire;
    logic [3:0]      payload;

    assign load     = (bit_ctr_q == 3'd7);
    assign bcr_fire = orbit_en && enable && (bc_q == bcr_offset);

    // Descending scan so the lowest pending index is the one left standing.
    always_comb begin
        ack_d   = '0;
        payload = 4'h0;
        if (bcr_fire) begin
            payload = bcr_code;
        end else if (enable) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    ack_d    = '0;
                    ack_d[i] = 1'b1;
                    payload  = req_code[4*i +: 4];
                end
            end
        end
    end

    // A zero payload frames to exactly the idle word, so no separate idle path is needed.
    always_comb begin
        sr_d = {sr_q[6:0], 1'b0};
        bc_d = bc_q;
        if (load) begin
            sr_d = {3'b110, payload, 1'b1};
            bc_d = (bc_q == BC_LAST) ? '0 : bc_q + BC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            bit_ctr_q <= 3'd0;
            sr_q      <= IDLE_WORD;
            bc_q      <= '0;
            ack_q     <= '0;
            strobe_q  <= 1'b0;
        end else begin
            bit_ctr_q <= bit_ctr_q + 3'd1;
            sr_q      <= sr_d;
            bc_q      <= bc_d;
            ack_q     <= load ? ack_d : '0;
            strobe_q  <= load;
        end
    end

`ifdef FC_SCHED_COLLISION_CNT_EN
    logic [15:0] coll_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            coll_q <= 16'h0000;
        end else if (load && bcr_fire && (|req) && (coll_q != 16'hFFFF)) begin
            coll_q <= coll_q + 16'd1;
        end
    end

    assign collision_count = coll_q;
`else
    assign collision_count = 16'h0000;
`endif

    assign fc_out      = sr_q[7];
    assign word_strobe = strobe_q;
    assign bc_count    = bc_q;
    assign ack         = ack_q;

endmodule

// File: tb/tb_fast_command_scheduler.sv
// Directed bench for fast_command_scheduler with a short 16-word orbit.
module tb_fast_command_scheduler;

    localparam int NREQ = 4;
    localparam int BC_W = 12;

    logic              clk = 1'b0;
    logic              arstn = 1'b1;
    logic              enable = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [4*NREQ-1:0] req_code = '0;
    logic [NREQ-1:0]   ack;
    logic              orbit_en = 1'b0;
    logic [3:0]        bcr_code = 4'h0;
    logic [BC_W-1:0]   bcr_offset = '0;
    logic              fc_out;
    logic              word_strobe;
    logic [BC_W-1:0]   bc_count;
    logic [15:0]       collision_count;

    int total = 0;
    int bad   = 0;

    fast_command_scheduler #(.NREQ(NREQ), .ORBIT_LEN(16), .BC_W(BC_W)) dut (
        .clk(clk), .arstn(arstn), .enable(enable), .req(req), .req_code(req_code),
        .ack(ack), .orbit_en(orbit_en), .bcr_code(bcr_code), .bcr_offset(bcr_offset),
        .fc_out(fc_out), .word_strobe(word_strobe), .bc_count(bc_count),
        .collision_count(collision_count)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for the next word_strobe and shifts in the whole word; returns in bit 7's cycle.
    task automatic get_word(output logic [7:0] w, output logic [NREQ-1:0] a,
                            output logic [NREQ-1:0] a_next, output logic [BC_W-1:0] bc,
                            output int waited);
        w = 'x; a = 'x; a_next = 'x; bc = 'x; waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            waited++;
            if (word_strobe) break;
        end
        if (!word_strobe) return;
        a    = ack;
        bc   = bc_count;
        w[7] = fc_out;
        for (int k = 6; k >= 0; k--) begin
            @(posedge clk); #1;
            if (k == 6) a_next = ack;
            w[k] = fc_out;
        end
    endtask

    // Collects the first word straight out of reset (released inside cycle 0).
    task automatic get_reset_word(output logic [7:0] w, output logic strobe_seen);
        strobe_seen = word_strobe;
        w[7] = fc_out;
        for (int k = 6; k >= 0; k--) begin
            @(posedge clk); #1;
            strobe_seen = strobe_seen | word_strobe;
            w[k] = fc_out;
        end
    endtask

    task automatic test_reset();
        logic [7:0] w; logic [NREQ-1:0] a, an; logic [BC_W-1:0] bc; int wt; logic ss;
        #3 arstn = 1'b0;
        #1;
        total++; if (fc_out !== 1'b1) begin bad++; $display("FAIL reset_fc_out got=%b exp=1", fc_out); end
        total++; if (bc_count !== 12'd0) begin bad++; $display("FAIL reset_bc got=%0d exp=0", bc_count); end
        total++; if (ack !== 4'h0 || word_strobe !== 1'b0) begin bad++; $display("FAIL reset_ack_strobe ack=%b strobe=%b exp=0000/0", ack, word_strobe); end
        total++; if (collision_count !== 16'h0) begin bad++; $display("FAIL reset_coll got=%0d exp=0", collision_count); end
        @(posedge clk); @(posedge clk); #1;
        arstn = 1'b1;
        get_reset_word(w, ss);
        total++; if (w !== 8'hC1 || ss !== 1'b0) begin bad++; $display("FAIL reset_first_word got=%h strobe=%b exp=c1/0", w, ss); end
        for (int n = 1; n <= 2; n++) begin
            get_word(w, a, an, bc, wt);
            total++; if (w !== 8'hC1 || a !== 4'h0 || bc !== BC_W'(n) || wt != 1) begin
                bad++; $display("FAIL idle_word%0d got=%h ack=%b bc=%0d wait=%0d exp=c1/0000/%0d/1", n, w, a, bc, wt, n);
            end
        end
    endtask

    task automatic test_priority();
        logic [7:0] w; logic [NREQ-1:0] a, an; logic [BC_W-1:0] bc; int wt;
        req_code = 16'h0A03;
        req      = 4'b0101;
        get_word(w, a, an, bc, wt);
        total++; if (w !== 8'hC7 || a !== 4'b0001 || an !== 4'b0000 || wt != 1) begin
            bad++; $display("FAIL prio_req0 got=%h ack=%b ack_next=%b wait=%0d exp=c7/0001/0000/1", w, a, an, wt);
        end
        req[0] = 1'b0;
        get_word(w, a, an, bc, wt);
        total++; if (w !== 8'hD5 || a !== 4'b0100 || wt != 1) begin
            bad++; $display("FAIL prio_req2 got=%h ack=%b wait=%0d exp=d5/0100/1", w, a, wt);
        end
        req[2] = 1'b0;
        get_word(w, a, an, bc, wt);
        total++; if (w !== 8'hC1 || a !== 4'b0000) begin bad++; $display("FAIL prio_after got=%h ack=%b exp=c1/0000", w, a); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w; logic [NREQ-1:0] a, an; logic [BC_W-1:0] bc; int wt;
        req_code = 16'h0050;
        req      = 4'b0010;
        for (int n = 0; n < 2; n++) begin
            get_word(w, a, an, bc, wt);
            total++; if (w !== 8'hCB || a !== 4'b0010 || wt != 1) begin
                bad++; $display("FAIL b2b_word%0d got=%h ack=%b wait=%0d exp=cb/0010/1", n, w, a, wt);
            end
        end
        req      = 4'b1000;
        req_code = 16'h0000;
        get_word(w, a, an, bc, wt);
        total++; if (w !== 8'hC1 || a !== 4'b1000) begin bad++; $display("FAIL zero_payload got=%h ack=%b exp=c1/1000", w, a); end
        req = 4'b0000;
    endtask

    task automatic test_bcr();
        logic [7:0] w; logic [NREQ-1:0] a, an; logic [BC_W-1:0] bc; int wt;
        orbit_en = 1'b1; bcr_offset = 12'd5; bcr_code = 4'h1;
        bc = '0;
        for (int n = 0; n < 20; n++) begin
            get_word(w, a, an, bc, wt);
            if (bc === 12'd6 || wt != 1) break;
        end
        total++; if (w !== 8'hC3 || bc !== 12'd6 || a !== 4'h0) begin
            bad++; $display("FAIL bcr_first got=%h bc=%0d ack=%b exp=c3/6/0000", w, bc, a);
        end
        for (int k = 1; k <= 16; k++) begin
            get_word(w, a, an, bc, wt);
            total++; if (w !== ((k == 16) ? 8'hC3 : 8'hC1) || bc !== BC_W'((6 + k) % 16) || wt != 1) begin
                bad++; $display("FAIL bcr_orbit%0d got=%h bc=%0d wait=%0d exp=%h/%0d/1", k, w, bc, wt,
                                (k == 16) ? 8'hC3 : 8'hC1, (6 + k) % 16);
            end
        end
    endtask

    task automatic test_collision();
        logic [7:0] w; logic [NREQ-1:0] a, an; logic [BC_W-1:0] bc; int wt;
        logic [15:0] exp_coll;
`ifdef FC_SCHED_COLLISION_CNT_EN
        exp_coll = 16'd1;
`else
        exp_coll = 16'd0;
`endif
        for (int n = 0; n < 20; n++) begin
            get_word(w, a, an, bc, wt);
            if (bc === 12'd5 || wt != 1) break;
        end
        req_code = 16'h0070;
        req      = 4'b0010;
        get_word(w, a, an, bc, wt);
        total++; if (w !== 8'hC3 || a !== 4'h0 || bc !== 12'd6) begin
            bad++; $display("FAIL coll_bcr got=%h ack=%b bc=%0d exp=c3/0000/6", w, a, bc);
        end
        get_word(w, a, an, bc, wt);
        total++; if (w !== 8'hCF || a !== 4'b0010) begin bad++; $display("FAIL coll_req1 got=%h ack=%b exp=cf/0010", w, a); end
        req = 4'b0000;
        total++; if (collision_count !== exp_coll) begin
            bad++; $display("FAIL coll_count got=%0d exp=%0d", collision_count, exp_coll);
        end
    endtask

    task automatic test_offset_oob();
        logic [7:0] w; logic [NREQ-1:0] a, an; logic [BC_W-1:0] bc; int wt;
        int non_idle;
        bcr_offset = 12'd16;
        non_idle   = 0;
        for (int n = 0; n < 17; n++) begin
            get_word(w, a, an, bc, wt);
            if (w !== 8'hC1) non_idle++;
        end
        total++; if (non_idle != 0) begin bad++; $display("FAIL bcr_oob non_idle_words=%0d exp=0", non_idle); end
        orbit_en = 1'b0;
    endtask

    task automatic test_enable();
        logic [7:0] w; logic [NREQ-1:0] a, an; logic [BC_W-1:0] bc; int wt;
        enable   = 1'b0;
        req_code = 16'h0003;
        req      = 4'b0001;
        for (int n = 0; n < 3; n++) begin
            get_word(w, a, an, bc, wt);
            total++; if (w !== 8'hC1 || a !== 4'h0 || wt != 1) begin
                bad++; $display("FAIL en_off%0d got=%h ack=%b wait=%0d exp=c1/0000/1", n, w, a, wt);
            end
        end
        enable = 1'b1;
        get_word(w, a, an, bc, wt);
        total++; if (w !== 8'hC7 || a !== 4'b0001) begin bad++; $display("FAIL en_on got=%h ack=%b exp=c7/0001", w, a); end
    endtask

    task automatic test_arst_mid();
        logic [7:0] w; logic [NREQ-1:0] a, an; logic [BC_W-1:0] bc; int wt; logic ss;
        // req[0] still pending from the enable test, so this word is c7.
        @(posedge clk); #1;
        total++; if (word_strobe !== 1'b1 || ack !== 4'b0001) begin
            bad++; $display("FAIL arst_pre strobe=%b ack=%b exp=1/0001", word_strobe, ack);
        end
        req = 4'b0000;
        repeat (3) begin @(posedge clk); #1; end
        total++; if (fc_out !== 1'b0) begin bad++; $display("FAIL arst_midword_bit got=%b exp=0", fc_out); end
        arstn = 1'b0;
        #1;
        total++; if (fc_out !== 1'b1 || bc_count !== 12'd0 || word_strobe !== 1'b0 || ack !== 4'h0 || collision_count !== 16'h0) begin
            bad++; $display("FAIL arst_async fc=%b bc=%0d strobe=%b ack=%b coll=%0d exp=1/0/0/0000/0",
                            fc_out, bc_count, word_strobe, ack, collision_count);
        end
        @(posedge clk); @(posedge clk); #1;
        arstn = 1'b1;
        get_reset_word(w, ss);
        total++; if (w !== 8'hC1 || ss !== 1'b0) begin bad++; $display("FAIL arst_idle_word got=%h strobe=%b exp=c1/0", w, ss); end
        get_word(w, a, an, bc, wt);
        total++; if (w !== 8'hC1 || bc !== 12'd1 || wt != 1) begin
            bad++; $display("FAIL arst_next got=%h bc=%0d wait=%0d exp=c1/1/1", w, bc, wt);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_back_to_back();
        test_bcr();
        test_collision();
        test_offset_oob();
        test_enable();
        test_arst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
